// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings,
// default geometry, and an op-class helper.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5,
      MD_NOP6  = 3'd6,
      MD_NOP7  = 3'd7
   } md_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   localparam int MD_WIDTH_DEF    = 32;
   localparam int MD_MULT_LAT_DEF = 5;
   localparam int MD_DIV_LAT_DEF  = 10;

   // True for the ops that occupy the unit for several cycles.
   function automatic logic md_is_arith(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_lat_ctr.sv
// Loadable down-counter that times a multi-cycle operation; done is high
// while the count is zero, i.e. on the last busy cycle.
module md_lat_ctr #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic          done
);

   logic [CW-1:0] count;

   // Load takes priority; otherwise count down and park at zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/md_unit_param.sv
// Parametrised multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed when the operation is accepted and held in a
// pending register; hi/lo only change at commit, MTHI/MTLO or reset.
// Optional macro MD_EARLY_OUT_EN: multiplies with a zero operand and
// divides by zero finish after a single busy cycle.
module md_unit_param
   import md_pkg::*;
#(
   parameter int WIDTH    = MD_WIDTH_DEF,
   parameter int MULT_LAT = MD_MULT_LAT_DEF,
   parameter int DIV_LAT  = MD_DIV_LAT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             flush,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0]    MULT_LD = CW'(MULT_LAT - 1);
   localparam logic [CW-1:0]    DIV_LD  = CW'(DIV_LAT - 1);
   localparam logic [WIDTH-1:0] ONES    = '1;
   localparam logic [WIDTH-1:0] MINV    = {1'b1, {(WIDTH-1){1'b0}}};

   // Full result {hi, lo} for an arithmetic op, including the divide corner cases.
   function automatic logic [2*WIDTH-1:0] md_calc(input logic [2:0] o,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic signed [WIDTH-1:0]   sa, sb, sq, sr;
      logic signed [2*WIDTH-1:0] sp;
      logic [2*WIDTH-1:0]        up;
      logic [2*WIDTH-1:0]        res;
      sa  = $signed(a);
      sb  = $signed(b);
      sq  = '0;
      sr  = '0;
      sp  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      up  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      res = '0;
      case (md_op_e'(o))
         MD_MULT:  res = sp;
         MD_MULTU: res = up;
         MD_DIV: begin
            if (b == '0) begin
               res = {a, ONES};
            end else if ((a == MINV) && (b == ONES)) begin
               res = {{WIDTH{1'b0}}, MINV};
            end else begin
               sq  = sa / sb;
               sr  = sa % sb;
               res = {sr, sq};
            end
         end
         MD_DIVU: begin
            if (b == '0) res = {a, ONES};
            else         res = {a % b, a / b};
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   md_state_e          state, state_nx;
   logic               launch, commit, mt_hi_wr, mt_lo_wr;
   logic               is_mult, early, ctr_load, ctr_done;
   logic [CW-1:0]      lat_ld, ctr_val;
   logic [2*WIDTH-1:0] pend;

   assign is_mult = (op == MD_MULT) || (op == MD_MULTU);

`ifdef MD_EARLY_OUT_EN
   assign early = is_mult ? ((rs_data == '0) || (rt_data == '0)) : (rt_data == '0);
`else
   assign early = 1'b0;
`endif

   assign lat_ld = early ? '0 : (is_mult ? MULT_LD : DIV_LD);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= MD_IDLE;
      else        state <= state_nx;
   end

   // Next state: accept in IDLE, leave RUN on the final cycle or on flush.
   always_comb begin
      state_nx = state;
      case (state)
         MD_IDLE: if (launch) state_nx = MD_RUN;
         MD_RUN:  if (flush || ctr_done) state_nx = MD_IDLE;
         default: state_nx = MD_IDLE;
      endcase
   end

   // FSM outputs; flush overrides both a new start and a final-cycle commit.
   always_comb begin
      busy     = (state == MD_RUN);
      launch   = (state == MD_IDLE) && start && !flush && md_is_arith(op);
      mt_hi_wr = (state == MD_IDLE) && start && !flush && (op == MD_MTHI);
      mt_lo_wr = (state == MD_IDLE) && start && !flush && (op == MD_MTLO);
      commit   = (state == MD_RUN) && ctr_done && !flush;
      ctr_load = launch || flush;
      ctr_val  = launch ? lat_ld : '0;
   end

   md_lat_ctr #(.CW(CW)) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .load     (ctr_load),
      .load_val (ctr_val),
      .dec      (busy),
      .done     (ctr_done)
   );

   // Capture the finished result when the operation is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      pend <= '0;
      else if (launch) pend <= md_calc(op, rs_data, rt_data);
   end

   // Architectural HI/LO: written by commit or by the move-to ops only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         hi <= pend[2*WIDTH-1:WIDTH];
         lo <= pend[WIDTH-1:0];
      end else begin
         if (mt_hi_wr) hi <= rs_data;
         if (mt_lo_wr) lo <= rs_data;
      end
   end

endmodule

// File: tb/tb_md_unit_param.sv
// Self-checking bench for md_unit_param: a table of arithmetic vectors plus
// hand-written sequences for move-to, flush, ignored start and async reset.
module tb_md_unit_param;

   localparam int ML = 5;
   localparam int DL = 10;
`ifdef MD_EARLY_OUT_EN
   localparam int EM = 1;
   localparam int ED = 1;
`else
   localparam int EM = ML;
   localparam int ED = DL;
`endif

   logic        clk = 1'b0;
   logic        reset, start, flush, busy;
   logic [2:0]  op;
   logic [31:0] rs_data, rt_data, hi, lo;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [31:0] eh;
      logic [31:0] el;
      string       nm;
   } vec_t;

   vec_t vt[$];

   md_unit_param #(.WIDTH(32), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .flush   (flush),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input int lat, input logic [31:0] eh, input logic [31:0] el,
                      input string nm);
      vec_t v;
      v.op = o; v.a = a; v.b = b; v.lat = lat; v.eh = eh; v.el = el; v.nm = nm;
      vt.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op and count busy cycles; hi/lo must hold until busy falls.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] eh, input logic [31:0] el,
                         input string nm);
      int   cnt;
      logic moved;
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      step();
      start = 1'b0; rs_data = 32'hDEADBEEF; rt_data = 32'hCAFEF00D;
      cnt = 0; moved = 1'b0;
      while (busy === 1'b1 && cnt < 200) begin
         cnt++;
         if (hi !== m_hi || lo !== m_lo) moved = 1'b1;
         step();
      end
      chk({nm, " latency"}, 32'(cnt), 32'(lat));
      chk({nm, " hold"}, {31'd0, moved}, 32'd0);
      chk({nm, " hi"}, hi, eh);
      chk({nm, " lo"}, lo, el);
      m_hi = eh; m_lo = el;
   endtask

   initial begin
      int cnt;
      reset = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0;
      rs_data = '0; rt_data = '0;

      add(3'd0, 32'hFFFFFFFE, 32'd3,        ML, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_m2x3");
      add(3'd1, 32'hFFFFFFFF, 32'd2,        ML, 32'h00000001, 32'hFFFFFFFE, "multu_max2");
      add(3'd2, 32'hFFFFFFF9, 32'd2,        DL, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2");
      add(3'd3, 32'd7,        32'd0,        ED, 32'h00000007, 32'hFFFFFFFF, "divu_d0");
      add(3'd2, 32'h80000000, 32'hFFFFFFFF, DL, 32'h00000000, 32'h80000000, "div_ovf");
      add(3'd2, 32'd7,        32'hFFFFFFFE, DL, 32'h00000001, 32'hFFFFFFFD, "div_7dm2");
      add(3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, DL, 32'hFFFFFFFF, 32'h00000003, "div_m7dm2");
      add(3'd3, 32'hFFFFFFF9, 32'd2,        DL, 32'h00000001, 32'h7FFFFFFC, "divu_big");
      add(3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, ML, 32'h3FFFFFFF, 32'h00000001, "mult_maxsq");
      add(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, ML, 32'h00000000, 32'h00000001, "mult_m1sq");
      add(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, ML, 32'hFFFFFFFE, 32'h00000001, "multu_maxsq");
      add(3'd0, 32'd12345,    32'd0,        EM, 32'h00000000, 32'h00000000, "mult_x0");
      add(3'd2, 32'hFFFFFFF9, 32'd0,        ED, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_d0");

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst hi", hi, 32'd0);
      chk("rst lo", lo, 32'd0);
      reset = 1'b1;
      step();

      for (int i = 0; i < vt.size(); i++)
         run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].lat, vt[i].eh, vt[i].el, vt[i].nm);

      // MTHI, then MULT 2*3 aborted on its 3rd busy cycle
      start = 1'b1; op = 3'd4; rs_data = 32'h1234; step();
      start = 1'b0;
      chk("mthi busy", {31'd0, busy}, 32'd0);
      chk("mthi hi", hi, 32'h1234);
      chk("mthi lo", lo, m_lo);
      m_hi = 32'h1234;
      start = 1'b1; op = 3'd0; rs_data = 32'd2; rt_data = 32'd3; step();
      start = 1'b0;
      step(); step();
      flush = 1'b1; step();
      flush = 1'b0;
      chk("flush busy", {31'd0, busy}, 32'd0);
      repeat (ML + 2) step();
      chk("flush hi", hi, 32'h1234);
      chk("flush lo", lo, m_lo);
      start = 1'b1; op = 3'd5; rs_data = 32'h55; step();
      start = 1'b0;
      chk("mtlo busy", {31'd0, busy}, 32'd0);
      chk("mtlo lo", lo, 32'h55);
      chk("mtlo hi", hi, 32'h1234);
      m_lo = 32'h55;

      // Flush on the final busy cycle: no commit
      start = 1'b1; op = 3'd0; rs_data = 32'd9; rt_data = 32'd9; step();
      start = 1'b0;
      repeat (ML - 1) step();
      chk("lastflush busy pre", {31'd0, busy}, 32'd1);
      flush = 1'b1; step();
      flush = 1'b0;
      chk("lastflush busy", {31'd0, busy}, 32'd0);
      chk("lastflush lo", lo, m_lo);
      chk("lastflush hi", hi, m_hi);

      // Flush in IDLE suppresses MTHI and MULT
      start = 1'b1; flush = 1'b1; op = 3'd4; rs_data = 32'hBAD0; step();
      chk("idleflush mthi", hi, m_hi);
      op = 3'd0; rs_data = 32'd4; rt_data = 32'd4; step();
      start = 1'b0; flush = 1'b0;
      chk("idleflush mult busy", {31'd0, busy}, 32'd0);
      step();
      chk("idleflush mult lo", lo, m_lo);

      // No-op encoding does nothing
      start = 1'b1; op = 3'd6; rs_data = 32'h77; rt_data = 32'h77; step();
      start = 1'b0;
      chk("nop busy", {31'd0, busy}, 32'd0);
      chk("nop hi", hi, m_hi);
      chk("nop lo", lo, m_lo);

      // Start while busy is ignored: DIV 100/7 with an MTHI pulse mid-flight
      start = 1'b1; op = 3'd2; rs_data = 32'd100; rt_data = 32'd7; step();
      start = 1'b0;
      cnt = 1;
      step(); cnt++;
      start = 1'b1; op = 3'd4; rs_data = 32'hDEAD; step(); cnt++;
      start = 1'b0;
      chk("ignored mthi", hi, m_hi);
      while (busy === 1'b1 && cnt < 200) begin
         cnt++;
         step();
      end
      chk("ignored latency", 32'(cnt), 32'(DL + 1));
      chk("ignored hi", hi, 32'd2);
      chk("ignored lo", lo, 32'd14);
      m_hi = 32'd2; m_lo = 32'd14;

      // Asynchronous reset on the 4th busy cycle of DIV
      start = 1'b1; op = 3'd2; rs_data = 32'd50; rt_data = 32'd3; step();
      start = 1'b0;
      repeat (3) step();
      chk("arst busy pre", {31'd0, busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("arst busy", {31'd0, busy}, 32'd0);
      chk("arst hi", hi, 32'd0);
      chk("arst lo", lo, 32'd0);
      step();
      reset = 1'b1;
      repeat (DL + 2) step();
      chk("arst no commit busy", {31'd0, busy}, 32'd0);
      chk("arst no commit lo", lo, 32'd0);
      m_hi = '0; m_lo = '0;

      // Unit is usable again after reset
      run_op(3'd3, 32'd50, 32'd3, DL, 32'd2, 32'd16, "post_rst_divu");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the 5-stage pipeline.
- Successor to the fixed-latency mult/div unit; used in the Execute stage.
- Adds configurable width and per-operation latency, pipeline flush/abort, and defined divide corner cases.
- Exports busy; the hazard unit stalls D while (start | busy) and an MD instruction is in D.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_LAT, 5, cycles busy is asserted for MULT/MULTU (>=1).
- DIV_LAT, 10, cycles busy is asserted for DIV/DIVU (>=1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  E-stage pulse: MD instruction valid this cycle.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-ops.
- rs_data  input  WIDTH  forwarded rs operand.
- rt_data  input  WIDTH  forwarded rt operand.
- flush  input  1  abort any in-flight operation (exception/pipeline kill).
- busy  output  1  operation in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, any time, asynchronous): hi=0, lo=0, busy=0, FSM=IDLE, counter=0, pending results cleared. Applies mid-operation; no result is committed.
- FSM has two states, IDLE and RUN.
- IDLE, start=1, op in 0–3, flush=0, sampled at edge t:
  - latch operands and op;
  - load counter with LAT-1 (LAT = MULT_LAT or DIV_LAT);
  - go to RUN; busy=1 from edge t.
- RUN: counter decrements each edge.
  - At the edge where counter==0: write hi/lo from the pending result, busy=0, go to IDLE.
  - busy is therefore high for exactly LAT cycles, and hi/lo are visible the cycle busy falls.
- MTHI/MTLO, in IDLE with start=1: write hi (resp. lo) from rs_data at that edge; busy stays 0; lo (resp. hi) unchanged.
- start while busy=1: ignored; no state change. The hazard unit guarantees this never occurs; the bench checks it is harmless.
- Multiply:
  - MULT signed, MULTU unsigned; 2*WIDTH-bit product.
  - hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide: lo = quotient, hi = remainder; quotient truncates toward zero; remainder takes the sign of the dividend (signed case).
  - Divisor 0 (both DIV and DIVU): lo = all ones, hi = dividend.
  - DIV with dividend = most-negative and divisor = -1: lo = most-negative, hi = 0.
- Flush:
  - flush=1 in RUN: go to IDLE, busy=0 next edge, hi/lo retain pre-operation values.
  - flush=1 in IDLE: suppresses any start that cycle, including MTHI/MTLO (flush wins).
- flush=1 at the final RUN edge (counter==0): abort wins; no commit.
- The result may be produced combinationally at latch time or iteratively. Required: latency exactly LAT, and hi/lo never change except at commit, MTHI/MTLO, or reset.

Optional Feature:
- Macro MD_EARLY_OUT_EN.
- Defined: MULT/MULTU with either operand 0, and DIV/DIVU with divisor 0, use LAT=1 (busy high one cycle, commit at the next edge).
- Undefined: all operations use the full MULT_LAT/DIV_LAT.
- Results are identical either way.

Decomposition:
- Shared package md_pkg:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO;
  - state encodings MD_IDLE, MD_RUN;
  - default latency constants.
- One sub-module, md_lat_ctr: loadable down-counter with a done flag, width $clog2(max(MULT_LAT,DIV_LAT)+1).

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3: busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=2: hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV rs=-7, rt=2: busy 10 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7/0: lo=0xFFFFFFFF, hi=7.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI rs=0x1234 then MULT 2*3, with flush asserted on the 3rd busy cycle: busy drops next edge, hi=0x1234 and lo unchanged. A following MTLO 0x55 gives lo=0x55 with no busy.
- Assert reset on the 4th busy cycle of DIV: busy=0 and hi=lo=0 immediately (asynchronous). With MD_EARLY_OUT_EN, MULT x*0 shows busy for exactly 1 cycle.
